// File: rtl/dmem_pkg.sv
// Shared types and load-extension helper for the synchronous data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } access_size_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Fill bit for a sub-word load: zero for unsigned loads, else the lane MSB.
  function automatic logic fill_bit(input logic [15:0] raw, input access_size_t sz,
                                    input logic uns);
    if (uns) begin
      fill_bit = 1'b0;
    end else if (sz == SZ_BYTE) begin
      fill_bit = raw[7];
    end else begin
      fill_bit = raw[15];
    end
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane extraction and sign/zero extension of a memory word.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int unsigned W   = 32,
  parameter int unsigned OFS = 2
) (
  input  logic [W-1:0]   word_i,
  input  logic [OFS-1:0] lane_i,
  input  access_size_t   size_i,
  input  logic           unsigned_i,
  output logic [W-1:0]   load_o_c
);

  logic [15:0] raw16;
  logic        fill;

  assign raw16 = 16'(word_i >> {lane_i, 3'b000});
  assign fill  = fill_bit(raw16, size_i, unsigned_i);

  always_comb begin
    load_o_c = word_i;
    case (size_i)
      SZ_BYTE: load_o_c = {{(W-8){fill}}, raw16[7:0]};
      SZ_HALF: load_o_c = {{(W-16){fill}}, raw16};
      default: load_o_c = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous byte-addressed data memory with self-initialisation and write-first reads.
// Optional access counters (rd_count/wr_count) are enabled by defining DMEM_PERF_EN.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned W          = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned INIT_WORDS = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         MemWrite,
  input  logic         MemRead,
  input  logic [1:0]   size,
  input  logic         unsigned_ld,
  input  logic [W-1:0] write_data,
  input  logic [N-1:0] address,
  output logic [W-1:0] read_data,
  output logic         read_valid,
  output logic         misaligned,
  output logic         busy
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int unsigned B     = W / 8;
  localparam int unsigned OFS   = $clog2(B);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]            mem_q [DEPTH];
  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   init_ptr_q, init_ptr_d;
  logic [W-1:0]            read_data_q, read_data_d;
  logic                    read_valid_q, read_valid_d;
  logic                    misaligned_q, misaligned_d;
  logic                    busy_q, busy_d;
`ifdef DMEM_PERF_EN
  logic [31:0]             rd_count_q, rd_count_d;
  logic [31:0]             wr_count_q, wr_count_d;
`endif

  access_size_t            sz_c;
  logic [OFS-1:0]          lane_c;
  logic [DEPTH_LOG2-1:0]   widx_c;
  logic                    aligned_c;
  logic                    ready_c;
  logic                    wr_acc_c, rd_acc_c, bad_c;
  logic [B-1:0]            byte_mask_c;
  logic [W-1:0]            bit_mask_c;
  logic [W-1:0]            wdata_sh_c;
  logic [W-1:0]            old_word_c;
  logic [W-1:0]            merged_c;
  logic [W-1:0]            load_c;
  logic [W-1:0]            init_val_c;
  logic                    mem_we_c;
  logic [DEPTH_LOG2-1:0]   mem_idx_c;
  logic [W-1:0]            mem_wdata_c;

  // Upper address bits alias; fold them so they are visibly consumed.
  generate
    if (N > OFS + DEPTH_LOG2) begin : g_addr_hi
      logic addr_hi_unused;
      assign addr_hi_unused = ^address[N-1:OFS+DEPTH_LOG2];
    end
  endgenerate

  assign sz_c       = access_size_t'(size);
  assign lane_c     = address[OFS-1:0];
  assign widx_c     = address[OFS+DEPTH_LOG2-1:OFS];
  assign ready_c    = (state_q == ST_READY);
  assign old_word_c = mem_q[widx_c];

  always_comb begin
    aligned_c = 1'b0;
    case (sz_c)
      SZ_BYTE: aligned_c = 1'b1;
      SZ_HALF: aligned_c = ~address[0];
      SZ_WORD: aligned_c = (lane_c == '0);
      default: aligned_c = 1'b0;
    endcase
  end

  assign wr_acc_c = ready_c & MemWrite & aligned_c;
  assign rd_acc_c = ready_c & MemRead & aligned_c;
  assign bad_c    = ready_c & (MemWrite | MemRead) & ~aligned_c;

  // Byte-lane write mask and the post-write word (feeds both storage and write-first read).
  always_comb begin
    byte_mask_c = '0;
    case (sz_c)
      SZ_BYTE: byte_mask_c = B'(1) << lane_c;
      SZ_HALF: byte_mask_c = B'(3) << lane_c;
      default: byte_mask_c = '1;
    endcase
    bit_mask_c = '0;
    for (int b = 0; b < int'(B); b++) begin
      bit_mask_c[b*8 +: 8] = {8{byte_mask_c[b]}};
    end
    wdata_sh_c = write_data << {lane_c, 3'b000};
    merged_c   = wr_acc_c ? ((old_word_c & ~bit_mask_c) | (wdata_sh_c & bit_mask_c))
                          : old_word_c;
  end

  dmem_lane_fmt #(.W(W), .OFS(OFS)) u_fmt (
    .word_i     (merged_c),
    .lane_i     (lane_c),
    .size_i     (sz_c),
    .unsigned_i (unsigned_ld),
    .load_o_c   (load_c)
  );

  assign init_val_c = ({1'b0, init_ptr_q} < (DEPTH_LOG2+1)'(INIT_WORDS)) ? W'(init_ptr_q) : '0;

  always_comb begin
    mem_we_c    = 1'b0;
    mem_idx_c   = widx_c;
    mem_wdata_c = merged_c;
    if (!ready_c) begin
      mem_we_c    = 1'b1;
      mem_idx_c   = init_ptr_q;
      mem_wdata_c = init_val_c;
    end else begin
      mem_we_c    = wr_acc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_idx_c] <= mem_wdata_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    misaligned_d = 1'b0;
`ifdef DMEM_PERF_EN
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
`endif
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + DEPTH_LOG2'(1);
        if (init_ptr_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        misaligned_d = bad_c;
        if (rd_acc_c) begin
          read_data_d  = load_c;
          read_valid_d = 1'b1;
        end
`ifdef DMEM_PERF_EN
        if (rd_acc_c && (rd_count_q != '1)) rd_count_d = rd_count_q + 32'd1;
        if (wr_acc_c && (wr_count_q != '1)) wr_count_d = wr_count_q + 32'd1;
`endif
      end
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      busy_q       <= 1'b1;
`ifdef DMEM_PERF_EN
      rd_count_q   <= '0;
      wr_count_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
      busy_q       <= busy_d;
`ifdef DMEM_PERF_EN
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
`endif
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign misaligned = misaligned_q;
  assign busy       = busy_q;
`ifdef DMEM_PERF_EN
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_sync.sv
// Directed, scoreboard-checked bench for dmem_sync (default parameters).
module tb_dmem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite, MemRead, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] write_data, address;
  logic [31:0] read_data;
  logic        read_valid, misaligned, busy;
`ifdef DMEM_PERF_EN
  logic [31:0] rd_count, wr_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb [$];
  logic [31:0] last_data;

  always #5 clk = ~clk;

  dmem_sync dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .write_data  (write_data),
    .address     (address),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .misaligned  (misaligned),
    .busy        (busy)
`ifdef DMEM_PERF_EN
    ,
    .rd_count    (rd_count),
    .wr_count    (wr_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access cycle: drive, queue the expected load, then check after the edge.
  task automatic access(input string tag, input logic we, input logic re, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_mis, input logic exp_valid, input logic [31:0] exp_data);
    logic [31:0] e;
    MemWrite = we; MemRead = re; size = sz; unsigned_ld = uns;
    address = addr; write_data = wd;
    if (exp_valid) sb.push_back(exp_data);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(read_valid), 32'(exp_valid));
    chk({tag, ".mis"}, 32'(misaligned), 32'(exp_mis));
    if (exp_valid) begin
      e = sb.pop_front();
      chk({tag, ".data"}, read_data, e);
      last_data = e;
    end else begin
      chk({tag, ".hold"}, read_data, last_data);
    end
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    while (cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy) break;
    end
    chk({tag, ".busy_cycles"}, 32'(cnt), 32'd1024);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; size = 2'b10;
    unsigned_ld = 1'b0; write_data = '0; address = '0; last_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.valid", 32'(read_valid), 32'd0);
    chk("rst.mis", 32'(misaligned), 32'd0);
    chk("rst.data", read_data, 32'd0);

    // Requests during INIT must be ignored (write to word 0 must not stick).
    rst_n = 1'b1;
    MemWrite = 1'b1; MemRead = 1'b1; size = 2'b10; address = 32'h0; write_data = 32'hFFFF_FFFF;
    begin
      int cnt;
      cnt = 0; pulses = 0;
      while (cnt < 3000) begin
        @(posedge clk); #1;
        cnt++;
        if (read_valid || misaligned) pulses++;
        if (!busy) break;
      end
      chk("init.busy_cycles", 32'(cnt), 32'd1024);
      chk("init.no_pulses", 32'(pulses), 32'd0);
    end
    MemWrite = 1'b0; MemRead = 1'b0;

    access("rd0",  0, 1, 2'b10, 0, 32'h0,  0, 0, 1, 32'd0);
    access("rd4",  0, 1, 2'b10, 0, 32'h4,  0, 0, 1, 32'd1);
    access("rd28", 0, 1, 2'b10, 0, 32'h28, 0, 0, 1, 32'd10);
    access("rd2c", 0, 1, 2'b10, 0, 32'h2C, 0, 0, 1, 32'd0);

    access("sw40", 1, 0, 2'b10, 0, 32'h40, 32'h8000_00F1, 0, 0, 0);
    access("lb",   0, 1, 2'b00, 0, 32'h40, 0, 0, 1, 32'hFFFF_FFF1);
    access("lbu",  0, 1, 2'b00, 1, 32'h40, 0, 0, 1, 32'h0000_00F1);
    access("lh",   0, 1, 2'b01, 0, 32'h42, 0, 0, 1, 32'hFFFF_8000);
    access("lhu",  0, 1, 2'b01, 1, 32'h42, 0, 0, 1, 32'h0000_8000);

    access("sw40b", 1, 0, 2'b10, 0, 32'h40, 32'h1122_3344, 0, 0, 0);
    access("sb41",  1, 0, 2'b00, 0, 32'h41, 32'hFFFF_FFAB, 0, 0, 0);
    access("lw40",  0, 1, 2'b10, 0, 32'h40, 0, 0, 1, 32'h1122_AB44);
    access("sh42",  1, 0, 2'b01, 0, 32'h42, 32'h0000_BEEF, 0, 0, 0);
    access("lw40h", 0, 1, 2'b10, 0, 32'h40, 0, 0, 1, 32'hBEEF_AB44);

    access("mis_lh43", 0, 1, 2'b01, 0, 32'h43, 0, 1, 0, 0);
    access("idle1",    0, 0, 2'b10, 0, 32'h0,  0, 0, 0, 0);
    access("sw44",     1, 0, 2'b10, 0, 32'h44, 32'h5566_7788, 0, 0, 0);
    access("mis_sw46", 1, 0, 2'b10, 0, 32'h46, 32'hDEAD_BEEF, 1, 0, 0);
    access("lw44",     0, 1, 2'b10, 0, 32'h44, 0, 0, 1, 32'h5566_7788);
    access("mis_rsvd_w", 1, 0, 2'b11, 0, 32'h40, 32'h0BAD_0BAD, 1, 0, 0);
    access("mis_rsvd_r", 0, 1, 2'b11, 0, 32'h40, 0, 1, 0, 0);
    access("lw40u",    0, 1, 2'b10, 0, 32'h40, 0, 0, 1, 32'hBEEF_AB44);

    access("wf80",   1, 1, 2'b10, 0, 32'h80, 32'h1234_5678, 0, 1, 32'h1234_5678);
    access("wf81b",  1, 1, 2'b00, 0, 32'h81, 32'h0000_0090, 0, 1, 32'hFFFF_FF90);
    access("sw80",   1, 0, 2'b10, 0, 32'h80, 32'hCAFE_F00D, 0, 0, 0);
    access("lw80",   0, 1, 2'b10, 0, 32'h80, 0, 0, 1, 32'hCAFE_F00D);
    access("alias",  0, 1, 2'b10, 0, 32'h1000_0004, 0, 0, 1, 32'd1);
    access("idle2",  0, 0, 2'b10, 0, 32'h0, 0, 0, 0, 0);
    access("lw0",    0, 1, 2'b10, 0, 32'h0, 0, 0, 1, 32'd0);

    // Reset in the middle of INIT restarts the full sequence.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    last_data = '0;
    repeat (500) @(posedge clk);
    #1;
    chk("mid.busy500", 32'(busy), 32'd1);
    rst_n = 1'b0; #2;
    chk("mid.rst_busy", 32'(busy), 32'd1);
    chk("mid.rst_data", read_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("mid");
    access("reinit40", 0, 1, 2'b10, 0, 32'h40, 0, 0, 1, 32'd0);
    access("reinit28", 0, 1, 2'b10, 0, 32'h28, 0, 0, 1, 32'd10);
    access("perf_w1",  1, 0, 2'b10, 0, 32'h100, 32'h0000_0077, 0, 0, 0);
    access("perf_mis", 0, 1, 2'b10, 0, 32'h102, 0, 1, 0, 0);
    access("perf_rw",  1, 1, 2'b01, 1, 32'h104, 32'h0000_9999, 0, 1, 32'h0000_9999);
`ifdef DMEM_PERF_EN
    chk("rd_count", rd_count, 32'd3);
    chk("wr_count", wr_count, 32'd2);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
